// File: rtl/host_mem_loader_if.sv
// Host-facing streams of host_mem_loader: load stream in (s_*) and readback stream out (m_*).
// The loader takes the slave view and the host bridge takes the master view.
interface host_mem_loader_if #(
    parameter int WIDTH_PARAM_MEM = 128,
    parameter int WIDTH_ACT_MEM   = 8
) ();
    logic                       s_valid;
    logic                       s_ready;
    logic [WIDTH_PARAM_MEM-1:0] s_data;
    logic                       m_valid;
    logic                       m_ready;
    logic [WIDTH_ACT_MEM-1:0]   m_data;

    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/host_mem_loader.sv
// Loads instruction/parameter/activation memories from a host stream, runs the core with a
// done timeout, then streams a window of activation memory back to the host.
module host_mem_loader #(
    parameter int WIDTH_ACT_MEM    = 8,
    parameter int WIDTH_PARAM_MEM  = 128,
    parameter int WIDTH_INST_MEM   = 80,
    parameter int WIDTH_ADDR_ACT   = 12,
    parameter int WIDTH_ADDR_PARAM = 13,
    parameter int WIDTH_ADDR_INST  = 6,
    parameter int TIMEOUT_W        = 20
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [WIDTH_ADDR_INST:0]    n_inst,
    input  logic [WIDTH_ADDR_PARAM:0]   n_param,
    input  logic [WIDTH_ADDR_ACT:0]     n_act_in,
    input  logic [WIDTH_ADDR_ACT-1:0]   act_wr_base,
    input  logic [WIDTH_ADDR_ACT-1:0]   act_rd_base,
    input  logic [WIDTH_ADDR_ACT:0]     n_act_out,
    host_mem_loader_if.slave            bus,
    output logic                        sel_ext,
    output logic                        en,
    output logic                        wea_instmem_ext,
    output logic                        wea_parammem_ext,
    output logic                        wea_actmem_ext,
    output logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext,
    output logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext,
    output logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext,
    output logic [WIDTH_INST_MEM-1:0]   instmem_in_ext,
    output logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext,
    output logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext,
    input  logic                        done,
    input  logic [WIDTH_ACT_MEM-1:0]    actmem_out,
    output logic                        busy,
    output logic                        job_done,
    output logic                        timeout
);
    localparam int AW_MAX = (WIDTH_ADDR_PARAM > WIDTH_ADDR_ACT) ?
                            ((WIDTH_ADDR_PARAM > WIDTH_ADDR_INST) ? WIDTH_ADDR_PARAM : WIDTH_ADDR_INST) :
                            ((WIDTH_ADDR_ACT > WIDTH_ADDR_INST) ? WIDTH_ADDR_ACT : WIDTH_ADDR_INST);
    localparam int CNT_W = AW_MAX + 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_LD_INST, ST_LD_PARAM, ST_LD_ACT, ST_RUN,
        ST_WAIT, ST_RD_ADDR, ST_RD_CAP, ST_RD_OUT, ST_FIN
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [CNT_W-1:0]            r_word, w_word_nxt, w_word_inc;
    logic [TIMEOUT_W-1:0]        r_tmo, w_tmo_nxt, w_tmo_inc;
    logic                        w_tmo_hit, w_latch, w_s_ready, w_accept;
    logic [WIDTH_ADDR_INST:0]    r_n_inst;
    logic [WIDTH_ADDR_PARAM:0]   r_n_param;
    logic [WIDTH_ADDR_ACT:0]     r_n_act_in, r_n_act_out;
    logic [WIDTH_ADDR_ACT-1:0]   r_wr_base, r_rd_base;
    logic                        r_sel, r_en, r_busy, r_job_done, r_timeout, r_m_valid;
    logic [WIDTH_ACT_MEM-1:0]    r_m_data;

    // Skipping zero-count phases: first non-empty load phase, else straight to RUN.
    function automatic state_t first_phase(input logic ni_nz, input logic np_nz, input logic na_nz);
        if (ni_nz)      return ST_LD_INST;
        else if (np_nz) return ST_LD_PARAM;
        else if (na_nz) return ST_LD_ACT;
        else            return ST_RUN;
    endfunction

    assign w_word_inc = r_word + CNT_W'(1);
    assign w_tmo_inc  = r_tmo + TIMEOUT_W'(1);
    assign w_accept   = bus.s_valid && w_s_ready;

    // Next-state, word counter and timeout counter.
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_tmo_nxt   = r_tmo;
        w_tmo_hit   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_word_nxt  = '0;
                    w_state_nxt = first_phase(|n_inst, |n_param, |n_act_in);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LD_INST, ST_LD_PARAM, ST_LD_ACT: begin
                if (w_accept) begin
                    w_word_nxt = w_word_inc;
                    if (r_state == ST_LD_INST && w_word_inc == CNT_W'(r_n_inst)) begin
                        w_word_nxt  = '0;
                        w_state_nxt = first_phase(1'b0, |r_n_param, |r_n_act_in);
                    end else if (r_state == ST_LD_PARAM && w_word_inc == CNT_W'(r_n_param)) begin
                        w_word_nxt  = '0;
                        w_state_nxt = first_phase(1'b0, 1'b0, |r_n_act_in);
                    end else if (r_state == ST_LD_ACT && w_word_inc == CNT_W'(r_n_act_in)) begin
                        w_word_nxt  = '0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                w_tmo_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_tmo_nxt = w_tmo_inc;
                if (done) begin
                    w_word_nxt  = '0;
                    w_state_nxt = (r_n_act_out == '0) ? ST_FIN : ST_RD_ADDR;
                end else if (w_tmo_inc == '1) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RD_ADDR: w_state_nxt = ST_RD_CAP;
            ST_RD_CAP:  w_state_nxt = ST_RD_OUT;
            ST_RD_OUT: begin
                if (bus.m_ready) begin
                    w_word_nxt  = w_word_inc;
                    w_state_nxt = (w_word_inc == CNT_W'(r_n_act_out)) ? ST_FIN : ST_RD_ADDR;
                end else begin
                    w_state_nxt = ST_RD_OUT;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write strobes, addresses and data are combinational so a write lands in its accept cycle;
    // resetn gates s_ready so nothing is accepted on the reset edge.
    always_comb begin
        w_s_ready         = resetn && (r_state == ST_LD_INST || r_state == ST_LD_PARAM ||
                                       r_state == ST_LD_ACT);
        wea_instmem_ext   = w_accept && (r_state == ST_LD_INST);
        wea_parammem_ext  = w_accept && (r_state == ST_LD_PARAM);
        wea_actmem_ext    = w_accept && (r_state == ST_LD_ACT);
        addr_instmem_ext  = '0;
        addr_parammem_ext = '0;
        addr_actmem_ext   = '0;
        instmem_in_ext    = '0;
        parammem_in_ext   = '0;
        actmem_in_ext     = '0;
        case (r_state)
            ST_LD_INST: begin
                addr_instmem_ext = r_word[WIDTH_ADDR_INST-1:0];
                instmem_in_ext   = bus.s_data[WIDTH_INST_MEM-1:0];
            end
            ST_LD_PARAM: begin
                addr_parammem_ext = r_word[WIDTH_ADDR_PARAM-1:0];
                parammem_in_ext   = bus.s_data;
            end
            ST_LD_ACT: begin
                addr_actmem_ext = r_wr_base + r_word[WIDTH_ADDR_ACT-1:0];
                actmem_in_ext   = bus.s_data[WIDTH_ACT_MEM-1:0];
            end
            ST_RD_ADDR, ST_RD_CAP: addr_actmem_ext = r_rd_base + r_word[WIDTH_ADDR_ACT-1:0];
            default: addr_actmem_ext = '0;
        endcase
    end

    // State, counters, latched job parameters and registered outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_tmo       <= '0;
            r_n_inst    <= '0;
            r_n_param   <= '0;
            r_n_act_in  <= '0;
            r_n_act_out <= '0;
            r_wr_base   <= '0;
            r_rd_base   <= '0;
            r_sel       <= 1'b0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_job_done  <= 1'b0;
            r_timeout   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_tmo      <= w_tmo_nxt;
            if (w_latch) begin
                r_n_inst    <= n_inst;
                r_n_param   <= n_param;
                r_n_act_in  <= n_act_in;
                r_n_act_out <= n_act_out;
                r_wr_base   <= act_wr_base;
                r_rd_base   <= act_rd_base;
            end
            if (r_state == ST_RD_CAP) begin
                r_m_data <= actmem_out;
            end
            r_sel      <= (w_state_nxt == ST_LD_INST) || (w_state_nxt == ST_LD_PARAM) ||
                          (w_state_nxt == ST_LD_ACT)  || (w_state_nxt == ST_RD_ADDR)  ||
                          (w_state_nxt == ST_RD_CAP)  || (w_state_nxt == ST_RD_OUT);
            r_en       <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_WAIT);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_job_done <= (w_state_nxt == ST_FIN);
            r_timeout  <= w_tmo_hit;
            r_m_valid  <= (w_state_nxt == ST_RD_OUT);
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign sel_ext     = r_sel;
    assign en          = r_en;
    assign busy        = r_busy;
    assign job_done    = r_job_done;
    assign timeout     = r_timeout;
endmodule

// File: tb/tb_host_mem_loader.sv
// Self-checking bench for host_mem_loader: a host stream feeder, a core memory model and a
// transaction-level reference of the writes and readback each job must produce.
module tb_host_mem_loader;
    localparam int TW = 4;

    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, done = 1'b0, mem_clr = 1'b1;
    logic [6:0] n_inst;
    logic [13:0] n_param;
    logic [12:0] n_act_in, n_act_out;
    logic [11:0] act_wr_base, act_rd_base;
    logic sel_ext, en, wea_i, wea_p, wea_a, busy, job_done, timeout;
    logic [5:0] addr_i;
    logic [12:0] addr_p;
    logic [11:0] addr_a;
    logic [79:0] inst_in;
    logic [127:0] param_in;
    logic [7:0] act_in, actmem_out;

    typedef struct {int mem; int addr; logic [127:0] data;} wr_t;
    wr_t wr_q[$];
    logic [7:0] act_mem [4096];
    logic [7:0] ref_act [4096];
    int total = 0, bad = 0, cyc = 0, last_wr = -1;

    host_mem_loader_if bus ();

    host_mem_loader #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .n_inst(n_inst), .n_param(n_param),
        .n_act_in(n_act_in), .act_wr_base(act_wr_base), .act_rd_base(act_rd_base),
        .n_act_out(n_act_out), .bus(bus), .sel_ext(sel_ext), .en(en),
        .wea_instmem_ext(wea_i), .wea_parammem_ext(wea_p), .wea_actmem_ext(wea_a),
        .addr_instmem_ext(addr_i), .addr_parammem_ext(addr_p), .addr_actmem_ext(addr_a),
        .instmem_in_ext(inst_in), .parammem_in_ext(param_in), .actmem_in_ext(act_in),
        .done(done), .actmem_out(actmem_out), .busy(busy), .job_done(job_done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core-side activation memory: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) act_mem[i] <= 8'h00;
        end else if (wea_a) begin
            act_mem[addr_a] <= act_in;
        end
        actmem_out <= act_mem[addr_a];
    end

    // Write monitor plus the sel/en/wea exclusivity rules.
    always @(negedge clk) begin
        wr_t e;
        chk("sel_en_rule", ((wea_i | wea_p | wea_a) & ~sel_ext) | (en & sel_ext), 1'b0);
        if (wea_i) begin e.mem = 0; e.addr = int'(addr_i); e.data = {48'h0, inst_in}; wr_q.push_back(e); end
        if (wea_p) begin e.mem = 1; e.addr = int'(addr_p); e.data = param_in; wr_q.push_back(e); end
        if (wea_a) begin e.mem = 2; e.addr = int'(addr_a); e.data = {120'h0, act_in}; wr_q.push_back(e); end
        if (wea_i | wea_p | wea_a) last_wr = cyc;
    end

    task automatic chk_all_zero(input string tag);
        chk(tag, {127'h0, |{bus.s_ready, bus.m_valid, bus.m_data, sel_ext, en, wea_i, wea_p, wea_a,
                            addr_i, addr_p, addr_a, inst_in, param_in, act_in, busy, job_done, timeout}}, 128'h0);
    endtask

    task automatic run_job(input int ni, np, na, wb, rb, no, done_dly, gap_at, gap_len,
                           stall_at, stall_len, input bit fixed_act, restart, exp_tmo);
        logic [127:0] words[$];
        logic [127:0] w;
        wr_t exp_q[$];
        wr_t e;
        logic [7:0] exp_rd[$];
        int tot = ni + np + na;
        int hidx = 0, gcnt = 0, scnt = 0, rd_i = 0, en_cnt = 0, jd_cnt = 0, tmo_cnt = 0;
        int first_en = -1, start_cyc = 0;
        for (int j = 0; j < tot; j++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (fixed_act && j >= ni + np) w[7:0] = 8'hA1 + 8'(j - ni - np);
            words.push_back(w);
            if (j < ni) begin e.mem = 0; e.addr = j % 64; e.data = {48'h0, w[79:0]}; end
            else if (j < ni + np) begin e.mem = 1; e.addr = (j - ni) % 8192; e.data = w; end
            else begin
                e.mem = 2; e.addr = (wb + j - ni - np) % 4096; e.data = {120'h0, w[7:0]};
                ref_act[e.addr] = w[7:0];
            end
            exp_q.push_back(e);
        end
        if (!exp_tmo) for (int i = 0; i < no; i++) exp_rd.push_back(ref_act[(rb + i) % 4096]);
        wr_q.delete();
        last_wr = -1;
        @(posedge clk) #1;
        n_inst = 7'(ni); n_param = 14'(np); n_act_in = 13'(na); n_act_out = 13'(no);
        act_wr_base = 12'(wb); act_rd_base = 12'(rb);
        start = 1'b1; start_cyc = cyc;
        bus.s_valid = (tot > 0);
        if (tot > 0) bus.s_data = words[0];
        bus.m_ready = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) hidx++;
            if (en) begin en_cnt++; if (first_en < 0) first_en = cyc; end
            if (bus.m_valid) begin
                if (rd_i < exp_rd.size()) chk("rd_data", {120'h0, bus.m_data}, {120'h0, exp_rd[rd_i]});
                else chk("rd_extra_valid", {127'h0, bus.m_valid}, 128'h0);
                if (bus.m_ready) rd_i++;
                else scnt++;
            end
            if (timeout) begin tmo_cnt++; chk("tmo_with_jd", {127'h0, job_done}, 128'h1); end
            if (job_done) begin jd_cnt++; break; end
            @(posedge clk) #1;
            start = restart && (k == 2);
            if (hidx == gap_at && gcnt < gap_len) begin bus.s_valid = 1'b0; gcnt++; end
            else bus.s_valid = (hidx < tot);
            if (hidx < tot) bus.s_data = words[hidx];
            bus.m_ready = !(rd_i == stall_at && scnt < stall_len);
            done = (done_dly >= 0) && (en_cnt >= done_dly);
        end
        chk("job_done_seen", 128'(jd_cnt), 128'd1);
        @(posedge clk) #1;
        done = 1'b0; start = 1'b0; bus.s_valid = 1'b0;
        @(negedge clk);
        chk("busy_after", {126'h0, busy, job_done}, 128'h0);
        chk("timeout_cnt", 128'(tmo_cnt), 128'(exp_tmo));
        chk("rd_count", 128'(rd_i), 128'(exp_rd.size()));
        chk("host_words", 128'(hidx), 128'(tot));
        chk("first_en", 128'(first_en), 128'((last_wr >= 0) ? last_wr + 1 : start_cyc + 1));
        if (exp_tmo) chk("en_cycles_tmo", 128'(en_cnt), 128'(2 ** TW));
        chk("wr_count", 128'(wr_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk("wr_mem", 128'(wr_q[i].mem), 128'(exp_q[i].mem));
            chk("wr_addr", 128'(wr_q[i].addr), 128'(exp_q[i].addr));
            chk("wr_data", wr_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        int np3;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        n_inst = '0; n_param = '0; n_act_in = '0; n_act_out = '0;
        act_wr_base = '0; act_rd_base = '0;
        for (int i = 0; i < 4096; i++) ref_act[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1; mem_clr = 1'b0;
        @(negedge clk);
        chk_all_zero("reset_outputs");

        // Reset in the middle of a 5-word parameter load, after 3 words.
        @(posedge clk) #1;
        n_param = 14'd5; start = 1'b1; bus.s_valid = 1'b1; bus.s_data = {4{$urandom()}};
        np3 = 0;
        for (int k = 0; k < 50 && np3 < 3; k++) begin
            @(negedge clk);
            if (wea_p) np3++;
            if (np3 < 3) begin
                @(posedge clk) #1;
                start = 1'b0; bus.s_data = {4{$urandom()}};
            end
        end
        chk("rst_mid_words", 128'(np3), 128'd3);
        @(posedge clk) #1 resetn = 1'b0;
        @(negedge clk);
        chk("rst_no_write", {126'h0, wea_p, bus.s_ready}, 128'h0);
        @(posedge clk) #1;
        resetn = 1'b1; bus.s_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid_outputs");
        run_job(0, 5, 0, 0, 0, 0, 4, -1, 0, -1, 0, 1'b0, 1'b0, 1'b0);

        // Directed load with a 2-cycle host gap inside the activation phase.
        run_job(2, 3, 4, 'h100, 0, 0, 5, 7, 2, -1, 0, 1'b0, 1'b0, 1'b0);
        // Readback window with a 4-cycle stall on the second word.
        run_job(0, 0, 3, 'hFF0, 'hFF0, 3, 10, -1, 0, 1, 4, 1'b1, 1'b0, 1'b0);
        // done never arrives.
        run_job(0, 0, 0, 0, 0, 2, -1, -1, 0, -1, 0, 1'b0, 1'b0, 1'b1);
        // Empty job with a second start while busy.
        run_job(0, 0, 0, 0, 0, 0, 6, -1, 0, -1, 0, 1'b0, 1'b1, 1'b0);
        // Full-depth instruction load and a wrapping readback window.
        run_job(64, 1, 3, 'hFFE, 'hFFE, 3, 3, -1, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            int wb = int'($urandom_range(0, 4095));
            run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    wb, (wb + int'($urandom_range(0, 3))) % 4096, int'($urandom_range(0, 5)),
                    int'($urandom_range(2, 12)), int'($urandom_range(0, 8)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/host_mem_loader.md
# host_mem_loader

Host-side initiator for the processor's external memory port. It streams instruction, parameter and input-activation words from a host valid/ready stream into the three on-chip memories. It then pulses the core `en`, waits for `done` with a timeout guard, and reads a result window of the activation memory back out on a valid/ready stream. It sits between the host bridge and `processor_top`, and is the only driver of `sel_ext`, `wea_*_ext`, `addr_*_ext`, `*_in_ext` and `en`.

## Interface
- WIDTH_ACT_MEM, 8, activation word width
- WIDTH_PARAM_MEM, 128, parameter word width; also host input stream width
- WIDTH_INST_MEM, 80, instruction word width
- WIDTH_ADDR_ACT / WIDTH_ADDR_PARAM / WIDTH_ADDR_INST, 12 / 13 / 6, memory address widths
- TIMEOUT_W, 20, width of the done-wait cycle counter
- clk  in  1  single clock, rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle job request; sampled only in IDLE
- n_inst / n_param / n_act_in  in  WIDTH_ADDR_x+1  words to load per memory; 0 skips that phase
- act_wr_base  in  WIDTH_ADDR_ACT  first activation write address
- act_rd_base  in  WIDTH_ADDR_ACT  first readback address
- n_act_out  in  WIDTH_ADDR_ACT+1  words to read back; 0 skips readback
- s_valid / s_ready  in / out  1  host input handshake
- s_data  in  WIDTH_PARAM_MEM  host word; instruction phase uses [79:0], activation phase uses [7:0]
- m_valid / m_ready  out / in  1  readback handshake
- m_data  out  WIDTH_ACT_MEM  readback word
- sel_ext, en, wea_instmem_ext, wea_parammem_ext, wea_actmem_ext  out  1  core controls
- addr_instmem_ext / addr_parammem_ext / addr_actmem_ext  out  per memory  core addresses
- instmem_in_ext / parammem_in_ext / actmem_in_ext  out  per memory  core write data
- done  in  1  core completion level
- actmem_out  in  WIDTH_ACT_MEM  core activation read data, one cycle after address
- busy / job_done / timeout  out  1  status; job_done and timeout are one-cycle pulses

## Operation
- States: IDLE, LD_INST, LD_PARAM, LD_ACT, RUN, WAIT, RD_ADDR, RD_CAP, RD_OUT, FIN.
- IDLE → LD_INST on start. Latch all count and base inputs at that edge. Phases with a zero count are skipped in the order INST → PARAM → ACT → RUN.
- LD_x: s_ready=1 and sel_ext=1. On each s_valid&&s_ready, assert the matching wea for that cycle and present the data and current address. Addresses start at 0, or at act_wr_base for activations, and increment by 1. Leave the phase on the accept of the last word.
- RUN: a single cycle with sel_ext=0 and en=1. The timeout counter is cleared. Then go to WAIT.
- WAIT: sel_ext=0 and en=1. The counter increments each cycle.
  - done=1 → RD_ADDR, or FIN if n_act_out=0.
  - Counter reaches all-ones with done still 0 → FIN, pulse timeout. No readback occurs.
- RD_ADDR: sel_ext=1, wea_actmem_ext=0, present the read address → RD_CAP.
- RD_CAP: capture actmem_out into m_data → RD_OUT.
- RD_OUT: m_valid=1, with m_data held stable until m_ready. On the handshake the address increments. If words remain → RD_ADDR, otherwise → FIN.
- FIN: pulse job_done (also on timeout) → IDLE.
- busy=1 in every state except IDLE.
- Address counters wrap modulo 2^WIDTH_ADDR_x. A count equal to the memory depth is legal.
- start outside IDLE is ignored.

## Timing
- Reset (resetn=0 at an edge) forces state IDLE on that edge, including mid-job. No partial write completes afterwards.
- Reset values are 0 on every output: s_ready, m_valid, m_data, sel_ext, en, all wea, all addr and data, busy, job_done, timeout.
- All outputs are registered, except s_ready and the write strobe/data/address, which are combinational from state and s_valid so that writes land in the accept cycle.
- Load throughput: 1 word/cycle.
- Readback: minimum 3 cycles/word with m_ready held high.
- Latency from start to the first write: 1 cycle, with the first word already valid.
- wea_*_ext is never 1 while sel_ext=0.
- en=0 whenever sel_ext=1.

## Test plan
- Reset mid-LD_PARAM after 3 of 5 words → next cycle all outputs 0, state IDLE; a following start reruns cleanly.
- n_inst=2, n_param=3, n_act_in=4, act_wr_base=0x100, continuous s_valid → writes at inst 0–1, param 0–2, act 0x100–0x103, each wea exactly 1 cycle; en rises 1 cycle after the last write.
- Gap in s_valid (2 idle cycles) during LD_ACT → no wea, address holds, resumes at the correct address.
- done asserted 10 cycles after en, n_act_out=3, act_rd_base=0xFF0, memory holds 0xA1, 0xA2, 0xA3 → m_data sequence 0xA1, 0xA2, 0xA3; m_ready stalled 4 cycles on the second word keeps m_data=0xA2 stable; job_done pulses once.
- TIMEOUT_W=4, done never asserted → timeout and job_done pulse together at WAIT cycle 15, no m_valid, busy falls the next cycle.
- All counts 0 → only the RUN/WAIT sequence; start during busy has no effect.
